// File: rtl/ptw_req_scheduler_pkg.sv
// Shared types and helpers for the PTW request scheduler and its picker.
package ptw_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } ptw_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptw_req_scheduler_rr_pick.sv
// Combinational round-robin picker: first valid requester after 'last'.
module rr_pick
  import ptw_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan last+1, last+2, ... modulo NUM_REQ; the first valid entry wins.
  always_comb begin
    int unsigned pos;
    logic [IDX_W-1:0] sel;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      pos = (32'(last) + off) % NUM_REQ;
      sel = IDX_W'(pos);
      if (!any && valid[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/ptw_req_scheduler.sv
// Round-robin arbiter sharing one PTW request port among NUM_REQ TLBs,
// with a single outstanding walk, response routing and flush/drain.
module ptw_req_scheduler
  import ptw_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned RESP_W  = 64
) (
  input  logic                      clk,
  input  logic                      rstnn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_need_gpa,
  output logic                      ptw_valid,
  input  logic                      ptw_ready,
  output logic [ADDR_W-1:0]         ptw_addr,
  output logic                      ptw_need_gpa,
  input  logic                      ptw_resp_valid,
  input  logic [RESP_W-1:0]         ptw_resp_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [RESP_W-1:0]         resp_data,
  input  logic                      flush,
  output logic                      busy,
  output logic                      spurious_err
);

  localparam int unsigned      IDX_W    = idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  ptw_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_q, owner_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               gpa_q;
  logic               spur_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               grant_fire;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant_fire = (state_q == ST_IDLE) && !flush && pick_any;

  // Next-state, request accept and response demux.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          req_ready = pick_grant;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An accepted request must be drained even if flushed this cycle.
        if (ptw_ready)  state_d = flush ? ST_DRAIN : ST_WAIT;
        else if (flush) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (ptw_resp_valid) begin
          resp_valid[owner_q] = 1'b1;
          state_d             = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ptw_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the granted request payload and rotation pointers.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      last_q  <= LAST_RST;
      owner_q <= '0;
      addr_q  <= '0;
      gpa_q   <= 1'b0;
    end else if (grant_fire) begin
      last_q  <= pick_idx;
      owner_q <= pick_idx;
      addr_q  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
      gpa_q   <= req_need_gpa[pick_idx];
    end
  end

  // Sticky flag for responses that arrive with no walk outstanding.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      spur_q <= 1'b0;
    end else if (ptw_resp_valid && (state_q == ST_IDLE || state_q == ST_ISSUE)) begin
      spur_q <= 1'b1;
    end
  end

  assign ptw_valid    = (state_q == ST_ISSUE);
  assign ptw_addr     = addr_q;
  assign ptw_need_gpa = gpa_q;
  assign resp_data    = ptw_resp_data;
  assign busy         = (state_q != ST_IDLE);
  assign spurious_err = spur_q;

endmodule

// File: tb/tb_ptw_req_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants and responses,
// a monitor compares them against the scheduler's outputs every cycle.
module tb_ptw_req_scheduler;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int RW = 64;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_need_gpa, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic            ptw_valid, ptw_ready, ptw_need_gpa, ptw_resp_valid, flush, busy, spurious_err;
  logic [AW-1:0]   ptw_addr;
  logic [RW-1:0]   ptw_resp_data, resp_data;

  ptw_req_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .RESP_W(RW)) dut (
    .clk            (clk),
    .rstnn          (rstnn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_need_gpa   (req_need_gpa),
    .ptw_valid      (ptw_valid),
    .ptw_ready      (ptw_ready),
    .ptw_addr       (ptw_addr),
    .ptw_need_gpa   (ptw_need_gpa),
    .ptw_resp_valid (ptw_resp_valid),
    .ptw_resp_data  (ptw_resp_data),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .flush          (flush),
    .busy           (busy),
    .spurious_err   (spurious_err)
  );

  typedef struct {
    int            who;
    logic [RW-1:0] data;
  } resp_t;

  int    grant_q[$];
  resp_t resp_q[$];
  int    seen_grants[$];

  // Model: walk lifecycle 0=no walk, 1=offered to PTW, 2=walk running, 3=discarding.
  int            m_phase, m_last, m_owner;
  logic [AW-1:0] m_addr;
  logic          m_gpa, m_spur;
  logic          e_pvalid, e_busy, e_spur, e_gpa;
  logic [AW-1:0] e_addr;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic int rr(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = N - 1; m_owner = 0;
    m_addr = '0; m_gpa = 1'b0; m_spur = 1'b0;
    e_pvalid = 1'b0; e_busy = 1'b0; e_spur = 1'b0; e_addr = '0; e_gpa = 1'b0;
    grant_q.delete();
    resp_q.delete();
  endtask

  task automatic model_step();
    int g;
    resp_t r;
    e_pvalid = (m_phase == 1);
    e_busy   = (m_phase != 0);
    e_spur   = m_spur;
    e_addr   = m_addr;
    e_gpa    = m_gpa;
    case (m_phase)
      0: begin
        if (ptw_resp_valid) m_spur = 1'b1;
        g = rr(req_valid, m_last);
        if (!flush && g >= 0) begin
          grant_q.push_back(g);
          m_last = g; m_owner = g;
          m_addr = req_addr[g*AW +: AW];
          m_gpa  = req_need_gpa[g];
          m_phase = 1;
        end
      end
      1: begin
        if (ptw_resp_valid) m_spur = 1'b1;
        if (ptw_ready)  m_phase = flush ? 3 : 2;
        else if (flush) m_phase = 0;
      end
      2: begin
        if (ptw_resp_valid) begin
          r.who = m_owner; r.data = ptw_resp_data;
          resp_q.push_back(r);
          m_phase = 0;
        end else if (flush) begin
          m_phase = 3;
        end
      end
      default: if (ptw_resp_valid) m_phase = 0;
    endcase
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N-1:0] g,
                       input logic pr, input logic rv, input logic [RW-1:0] rd, input logic fl);
    @(negedge clk);
    req_valid = v; req_addr = a; req_need_gpa = g;
    ptw_ready = pr; ptw_resp_valid = rv; ptw_resp_data = rd; flush = fl;
    #1 model_step();
  endtask

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom);
    return a;
  endfunction

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_need_gpa = '0;
    ptw_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_data = '0; flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, "_ptw_valid"}, 64'(ptw_valid), 64'(0));
    chk({tag, "_ptw_addr"}, 64'(ptw_addr), 64'(0));
    chk({tag, "_ptw_need_gpa"}, 64'(ptw_need_gpa), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_spurious_err"}, 64'(spurious_err), 64'(0));
  endtask

  // Monitor: compares DUT strobes against the scoreboard queues each cycle.
  always begin
    @(negedge clk);
    #3;
    if (mon_en) begin
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) seen_grants.push_back(i);
        if (grant_q.size() == 0) flag("unexpected_grant");
        else chk("grant", 64'(req_ready), 64'(1) << grant_q.pop_front());
      end
      if (grant_q.size() != 0) begin
        flag("missing_grant");
        grant_q.delete();
      end
      if (resp_valid != '0) begin
        if (resp_q.size() == 0) flag("unexpected_resp");
        else begin
          resp_t r;
          r = resp_q.pop_front();
          chk("resp_valid", 64'(resp_valid), 64'(1) << r.who);
          chk("resp_payload", resp_data, r.data);
        end
      end
      if (resp_q.size() != 0) begin
        flag("missing_resp");
        resp_q.delete();
      end
      chk("resp_data_passthru", resp_data, ptw_resp_data);
      chk("ptw_valid", 64'(ptw_valid), 64'(e_pvalid));
      if (e_pvalid) begin
        chk("ptw_addr", 64'(ptw_addr), 64'(e_addr));
        chk("ptw_need_gpa", 64'(ptw_need_gpa), 64'(e_gpa));
      end
      chk("busy", 64'(busy), 64'(e_busy));
      chk("spurious_err", 64'(spurious_err), 64'(e_spur));
    end
  end

  initial begin
    logic [N*AW-1:0] a;
    int exp_alt[4];
    exp_alt = '{0, 1, 0, 1};
    idle_inputs();
    model_reset();
    #2 check_reset_outputs("reset");
    @(negedge clk);
    rstnn = 1'b1;
    mon_en = 1'b1;

    // Two requesters contending: strict alternation, response 2 cycles after accept.
    a = '0;
    a[0*AW +: AW] = 20'h00011;
    a[1*AW +: AW] = 20'h00022;
    seen_grants.delete();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0011, a, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      drive(4'b0011, a, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      drive(4'b0011, a, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      drive(4'b0011, a, 4'b0000, 1'b1, 1'b1, 64'(100 + k), 1'b0);
    end
    drive('0, a, '0, 1'b0, 1'b0, '0, 1'b0);
    #3;
    chk("rr_alt_count", 64'(seen_grants.size()), 64'(4));
    for (int k = 0; k < 4 && k < seen_grants.size(); k++)
      chk("rr_alt_order", 64'(seen_grants[k]), 64'(exp_alt[k]));

    // Requester 1 held off by PTW back-pressure, then answered.
    a = '0;
    a[1*AW +: AW] = 20'hABCDE;
    drive(4'b0010, a, 4'b0010, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) drive('0, a, '0, 1'b0, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b1, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b0, 1'b1, 64'h1234, 1'b0);

    // Flush while offered, then a stray response.
    drive(4'b0001, rand_addrs(), '0, 1'b0, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b0, 1'b0, '0, 1'b1);
    drive('0, a, '0, 1'b0, 1'b1, 64'hDEAD, 1'b0);
    drive('0, a, '0, 1'b0, 1'b0, '0, 1'b0);

    // Flush during walk: response discarded, next grant accepted.
    drive(4'b0100, rand_addrs(), 4'b0100, 1'b1, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b1, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b0, 1'b0, '0, 1'b1);
    drive('0, a, '0, 1'b0, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b0, 1'b1, 64'hBEEF, 1'b0);
    drive(4'b0100, rand_addrs(), '0, 1'b1, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b1, 1'b0, '0, 1'b0);
    // Flush coinciding with the response: response still delivered.
    drive('0, a, '0, 1'b0, 1'b1, 64'hCAFE, 1'b1);

    // Wrap-around from last=2 with requesters 0 and 2 pending.
    seen_grants.delete();
    for (int k = 0; k < 2; k++) begin
      drive(4'b0101, rand_addrs(), 4'b0001, 1'b1, 1'b0, '0, 1'b0);
      drive(4'b0101, rand_addrs(), '0, 1'b1, 1'b0, '0, 1'b0);
      drive('0, a, '0, 1'b0, 1'b1, 64'(k), 1'b0);
    end
    drive('0, a, '0, 1'b0, 1'b0, '0, 1'b0);
    #3;
    chk("rr_wrap_count", 64'(seen_grants.size()), 64'(2));
    if (seen_grants.size() == 2) begin
      chk("rr_wrap_first", 64'(seen_grants[0]), 64'(0));
      chk("rr_wrap_second", 64'(seen_grants[1]), 64'(2));
    end

    // Randomized traffic.
    for (int k = 0; k < 2000; k++)
      drive(N'($urandom), rand_addrs(), N'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), {$urandom, $urandom}, ($urandom_range(0, 9) == 0));

    // Reset in the middle of a walk; a later response is spurious.
    drive(4'b1000, rand_addrs(), '0, 1'b1, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b1, 1'b0, '0, 1'b0);
    drive('0, a, '0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    mon_en = 1'b0;
    rstnn = 1'b0;
    idle_inputs();
    model_reset();
    #1 check_reset_outputs("midwalk_reset");
    @(negedge clk);
    rstnn = 1'b1;
    mon_en = 1'b1;
    drive('0, a, '0, 1'b0, 1'b1, 64'h5555, 1'b0);
    drive('0, a, '0, 1'b0, 1'b0, '0, 1'b0);

    // Randomized traffic with responses only while a walk is outstanding.
    for (int k = 0; k < 1500; k++)
      drive(N'($urandom), rand_addrs(), N'($urandom), 1'($urandom_range(0, 1)),
            (m_phase >= 2) && ($urandom_range(0, 2) == 0), {$urandom, $urandom},
            ($urandom_range(0, 14) == 0));

    for (int k = 0; k < 4; k++) drive('0, a, '0, 1'b0, 1'b0, '0, 1'b0);
    #3;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
